// File: rtl/accelerator_wrapper.sv
// AXI4 read-only burst master: one job issues C_NUM_BURSTS sequential INCR bursts and checks
// the response code, ID and RLAST framing of every beat. Read data is discarded.
module accelerator_wrapper #(
    parameter logic [31:0] C_M_TARGET_SLAVE_BASE_ADDR = 32'h4000_0000,
    parameter int unsigned C_NUM_BURSTS               = 4,
    parameter int unsigned C_M_AXI_BURST_LEN          = 256,
    parameter int unsigned C_M_AXI_ID_WIDTH           = 1,
    parameter int unsigned C_M_AXI_ADDR_WIDTH         = 32,
    parameter int unsigned C_M_AXI_DATA_WIDTH         = 16,
    parameter int          C_M_AXI_ARUSER_WIDTH       = 0,
    parameter int          C_M_AXI_RUSER_WIDTH        = 0
) (
    input  logic                              M_AXI_ACLK,
    input  logic                              M_AXI_ARESETN,
    input  logic                              INIT_AXI_TXN,
    output logic                              TXN_DONE,
    output logic                              ERROR,
    output logic [C_M_AXI_ID_WIDTH-1:0]       M_AXI_ARID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [7:0]                        M_AXI_ARLEN,
    output logic [2:0]                        M_AXI_ARSIZE,
    output logic [1:0]                        M_AXI_ARBURST,
    output logic                              M_AXI_ARLOCK,
    output logic [3:0]                        M_AXI_ARCACHE,
    output logic [2:0]                        M_AXI_ARPROT,
    output logic [3:0]                        M_AXI_ARQOS,
    output logic [C_M_AXI_ARUSER_WIDTH-1:0]   M_AXI_ARUSER,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,
    input  logic [C_M_AXI_ID_WIDTH-1:0]       M_AXI_RID,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RLAST,
    input  logic [C_M_AXI_RUSER_WIDTH-1:0]    M_AXI_RUSER,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY
);

    localparam int unsigned AW = C_M_AXI_ADDR_WIDTH;
    localparam logic [AW-1:0] BaseAddr   = AW'(C_M_TARGET_SLAVE_BASE_ADDR);
    localparam logic [AW-1:0] BurstBytes = AW'(C_M_AXI_BURST_LEN * (C_M_AXI_DATA_WIDTH / 8));
    localparam logic [7:0]    LastBeat   = 8'(C_M_AXI_BURST_LEN - 1);
    localparam logic [7:0]    LastBurst  = 8'(C_NUM_BURSTS - 1);

    typedef enum logic [1:0] {StIdle, StIssueAr, StReadData, StDone} state_e;

    state_e          state_q, state_d;
    logic            init_q, init_d;
    logic            arvalid_q, arvalid_d;
    logic            rready_q, rready_d;
    logic            txn_done_q, txn_done_d;
    logic            error_q, error_d;
    logic [AW-1:0]   araddr_q, araddr_d;
    logic [7:0]      burst_cnt_q, burst_cnt_d;
    logic [7:0]      beat_cnt_q, beat_cnt_d;

    logic init_pulse;
    logic beat;
    logic last_beat;
    logic beat_bad;

    always_comb begin
        state_d     = state_q;
        init_d      = INIT_AXI_TXN;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        txn_done_d  = txn_done_q;
        error_d     = error_q;
        araddr_d    = araddr_q;
        burst_cnt_d = burst_cnt_q;
        beat_cnt_d  = beat_cnt_q;

        init_pulse = INIT_AXI_TXN & ~init_q;
        beat       = M_AXI_RVALID & rready_q;
        last_beat  = (beat_cnt_q == LastBeat);
        // Framing is judged by our own beat count, not by RLAST.
        beat_bad   = M_AXI_RRESP[1] | (M_AXI_RID != '0) | (M_AXI_RLAST != last_beat);

        case (state_q)
            StIdle, StDone: begin
                if (init_pulse) begin
                    txn_done_d  = 1'b0;
                    error_d     = 1'b0;
                    burst_cnt_d = '0;
                    beat_cnt_d  = '0;
                    araddr_d    = BaseAddr;
                    state_d     = StIssueAr;
                end
            end
            StIssueAr: begin
                arvalid_d = 1'b1;
                if (arvalid_q && M_AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = StReadData;
                end
            end
            StReadData: begin
                if (beat) begin
                    if (beat_bad) begin
                        error_d = 1'b1;
                    end
                    if (last_beat) begin
                        rready_d    = 1'b0;
                        beat_cnt_d  = '0;
                        araddr_d    = araddr_q + BurstBytes;
                        burst_cnt_d = burst_cnt_q + 8'd1;
                        if (burst_cnt_q == LastBurst) begin
                            txn_done_d = 1'b1;
                            state_d    = StDone;
                        end else begin
                            state_d = StIssueAr;
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge M_AXI_ACLK) begin
        if (!M_AXI_ARESETN) begin
            state_q     <= StIdle;
            init_q      <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            txn_done_q  <= 1'b0;
            error_q     <= 1'b0;
            araddr_q    <= BaseAddr;
            burst_cnt_q <= '0;
            beat_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            init_q      <= init_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            txn_done_q  <= txn_done_d;
            error_q     <= error_d;
            araddr_q    <= araddr_d;
            burst_cnt_q <= burst_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
        end
    end

    assign TXN_DONE      = txn_done_q;
    assign ERROR         = error_q;
    assign M_AXI_ARID    = '0;
    assign M_AXI_ARADDR  = araddr_q;
    assign M_AXI_ARLEN   = LastBeat;
    assign M_AXI_ARSIZE  = 3'($clog2(C_M_AXI_DATA_WIDTH / 8));
    assign M_AXI_ARBURST = 2'b01;
    assign M_AXI_ARLOCK  = 1'b0;
    assign M_AXI_ARCACHE = 4'b0011;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARQOS   = 4'h0;
    assign M_AXI_ARUSER  = '1;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;

    logic unused_rsig;
    assign unused_rsig = ^{M_AXI_RDATA, M_AXI_RUSER, M_AXI_RRESP[0]};

endmodule

// File: tb/tb_accelerator_wrapper.sv
// Bench for accelerator_wrapper: a randomised AXI read slave plus a transaction-level model of
// the job (burst addresses, beat counts, error rules, completion) checked every cycle.
module tb_accelerator_wrapper;

    localparam logic [31:0] BASE   = 32'h4000_0000;
    localparam int          NB     = 4;
    localparam int          LEN    = 256;
    localparam int          ID_W   = 1;
    localparam int          AW     = 32;
    localparam int          DW     = 16;
    localparam int          ARU_W  = 0;
    localparam int          RU_W   = 0;
    localparam int          BBYTES = LEN * DW / 8;

    logic              clk;
    logic              rst_n;
    logic              init;
    logic              txn_done;
    logic              err;
    logic [ID_W-1:0]   arid;
    logic [AW-1:0]     araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arlock;
    logic [3:0]        arcache;
    logic [2:0]        arprot;
    logic [3:0]        arqos;
    logic [ARU_W-1:0]  aruser;
    logic              arvalid;
    logic              arready;
    logic [ID_W-1:0]   rid;
    logic [DW-1:0]     rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic [RU_W-1:0]   ruser;
    logic              rvalid;
    logic              rready;

    accelerator_wrapper #(
        .C_M_TARGET_SLAVE_BASE_ADDR (BASE),
        .C_NUM_BURSTS               (NB),
        .C_M_AXI_BURST_LEN          (LEN),
        .C_M_AXI_ID_WIDTH           (ID_W),
        .C_M_AXI_ADDR_WIDTH         (AW),
        .C_M_AXI_DATA_WIDTH         (DW),
        .C_M_AXI_ARUSER_WIDTH       (ARU_W),
        .C_M_AXI_RUSER_WIDTH        (RU_W)
    ) dut (
        .M_AXI_ACLK    (clk),
        .M_AXI_ARESETN (rst_n),
        .INIT_AXI_TXN  (init),
        .TXN_DONE      (txn_done),
        .ERROR         (err),
        .M_AXI_ARID    (arid),
        .M_AXI_ARADDR  (araddr),
        .M_AXI_ARLEN   (arlen),
        .M_AXI_ARSIZE  (arsize),
        .M_AXI_ARBURST (arburst),
        .M_AXI_ARLOCK  (arlock),
        .M_AXI_ARCACHE (arcache),
        .M_AXI_ARPROT  (arprot),
        .M_AXI_ARQOS   (arqos),
        .M_AXI_ARUSER  (aruser),
        .M_AXI_ARVALID (arvalid),
        .M_AXI_ARREADY (arready),
        .M_AXI_RID     (rid),
        .M_AXI_RDATA   (rdata),
        .M_AXI_RRESP   (rresp),
        .M_AXI_RLAST   (rlast),
        .M_AXI_RUSER   (ruser),
        .M_AXI_RVALID  (rvalid),
        .M_AXI_RREADY  (rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Stimulus knobs
    int p_ar, ar_delay, p_rv, rv_toggle, err_burst, err_beat, err_kind;

    // Reference model state
    bit  active, exp_done, exp_err, exp_arv, exp_rready, init_prev;
    int  lat, issued, bursts_done, beat_idx, total_beats, arv_wait;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        active = 0; exp_done = 0; exp_err = 0; exp_arv = 0; exp_rready = 0;
        init_prev = 0; lat = 0; issued = 0; bursts_done = 0; beat_idx = 0; arv_wait = 0;
    endtask

    // Runs at the negedge: compare outputs, then account for what the next posedge consumes.
    task automatic model_cycle();
        bit pulse;
        bit bad;
        check_eq("txn_done", {63'd0, txn_done}, {63'd0, exp_done});
        check_eq("error", {63'd0, err}, {63'd0, exp_err});
        check_eq("rready", {63'd0, rready}, {63'd0, exp_rready});
        if (lat > 0) begin
            lat--;
            if (lat == 0) exp_arv = 1;
        end
        check_eq("arvalid", {63'd0, arvalid}, {63'd0, exp_arv});
        if (arvalid)
            check_eq("araddr", 64'(araddr), 64'(BASE + 32'(issued * BBYTES)));

        if (!rst_n) begin
            model_reset();
            return;
        end
        pulse = init && !init_prev;
        init_prev = init;
        if (pulse && !active) begin
            active = 1; exp_done = 0; exp_err = 0; issued = 0; bursts_done = 0;
            beat_idx = 0; total_beats = 0; lat = 2; exp_arv = 0;
        end
        if (arvalid && arready) begin
            if (ar_delay >= 0) check_eq("ar_wait", 64'(arv_wait), 64'(ar_delay));
            exp_arv = 0; exp_rready = 1; issued++; arv_wait = 0;
        end else if (arvalid) begin
            arv_wait++;
        end
        if (rvalid && rready) begin
            bad = (rresp >= 2'd2) || (rid != '0) || (rlast != (beat_idx == LEN - 1));
            if (bad) exp_err = 1;
            beat_idx++;
            total_beats++;
            if (beat_idx == LEN) begin
                beat_idx = 0; bursts_done++; exp_rready = 0;
                if (bursts_done == NB) begin
                    exp_done = 1; active = 0;
                end else begin
                    lat = 2;
                end
            end
        end
    endtask

    task automatic drive_inputs();
        if (ar_delay >= 0) arready = (arv_wait >= ar_delay);
        else arready = ($urandom_range(99) < p_ar);
        if (rv_toggle != 0) rvalid = ~rvalid;
        else rvalid = ($urandom_range(99) < p_rv);
        rdata = DW'($urandom);
        if (rvalid) begin
            rresp = {1'b0, 1'($urandom_range(1))};
            rid   = '0;
            rlast = (beat_idx == LEN - 1);
            if (bursts_done == err_burst && beat_idx == err_beat) begin
                case (err_kind)
                    1: rresp = 2'b10;
                    2: rlast = 1'b1;
                    3: rlast = 1'b0;
                    4: rid = ID_W'(1);
                    default: ;
                endcase
            end
        end else begin
            rresp = 2'($urandom_range(3));
            rid   = ID_W'($urandom_range(1));
            rlast = 1'($urandom_range(1));
        end
    endtask

    task automatic step();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
        drive_inputs();
    endtask

    task automatic knobs(input int a, input int d, input int v, input int t, input int eb,
                         input int ebt, input int ek);
        p_ar = a; ar_delay = d; p_rv = v; rv_toggle = t;
        err_burst = eb; err_beat = ebt; err_kind = ek;
    endtask

    task automatic start_job();
        init = 1'b0;
        step();
        init = 1'b1;
        step();
    endtask

    task automatic wait_job(input string tag, input bit want_err);
        int n = 0;
        while (!exp_done && n < 8000) begin
            step();
            n++;
        end
        check_eq({tag, "_timeout"}, {63'd0, n < 8000}, 64'd1);
        step();
        check_eq({tag, "_done"}, {63'd0, txn_done}, 64'd1);
        check_eq({tag, "_err"}, {63'd0, err}, {63'd0, want_err});
        check_eq({tag, "_beats"}, 64'(total_beats), 64'(NB * LEN));
        check_eq({tag, "_bursts"}, 64'(issued), 64'(NB));
    endtask

    initial begin
        model_reset();
        total_beats = 0;
        knobs(100, -1, 100, 0, -1, -1, 0);
        rst_n = 1'b0; init = 1'b1;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0; rid = '0; rlast = 1'b0;
        ruser = '0;
        repeat (3) step();
        check_eq("arlen", 64'(arlen), 64'd255);
        check_eq("arsize", 64'(arsize), 64'd1);
        check_eq("arburst", 64'(arburst), 64'd1);
        check_eq("arcache", 64'(arcache), 64'd3);
        check_eq("ar_misc", {54'd0, arid, arlock, arprot, arqos}, 64'd0);

        // INIT held through reset starts a job right after release
        rst_n = 1'b1;
        wait_job("clean", 1'b0);

        knobs(100, 5, 70, 0, -1, -1, 0);
        start_job();
        wait_job("ar_stall", 1'b0);

        knobs(50, -1, 80, 0, 2, 17, 1);
        start_job();
        wait_job("slverr", 1'b1);

        knobs(60, -1, 90, 0, 0, 100, 2);
        start_job();
        wait_job("early_last", 1'b1);

        knobs(60, -1, 90, 0, 3, LEN - 1, 3);
        start_job();
        wait_job("no_last", 1'b1);

        knobs(100, -1, 0, 1, -1, -1, 0);
        start_job();
        wait_job("toggle", 1'b0);

        knobs(40, -1, 60, 0, 1, 0, 4);
        start_job();
        wait_job("bad_rid", 1'b1);

        // Abort mid-burst, then restart from the base address
        knobs(100, -1, 100, 0, -1, -1, 0);
        start_job();
        repeat (300) step();
        init = 1'b0;
        rst_n = 1'b0;
        step();
        check_eq("rst_rready", {63'd0, rready}, 64'd0);
        check_eq("rst_arvalid", {63'd0, arvalid}, 64'd0);
        check_eq("rst_araddr", 64'(araddr), 64'(BASE));
        rst_n = 1'b1;
        repeat (4) step();
        start_job();
        wait_job("restart", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
